id_regfile_scoreboard: RTL and testbench



---
 rtl/id_regfile_scoreboard.sv | 102 ++++++++++
 tb/tb_id_regfile_scoreboard.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_regfile_scoreboard.sv
// Decode-stage register file with write-back bypass and a per-register
// latency scoreboard that stalls dependents of multi-cycle producers.
module id_regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int LAT_W = 3,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic                flush,
  input  logic [NRD*AW-1:0]   rs_addr,
  input  logic [NRD-1:0]      rs_used,
  input  logic                rd_we,
  input  logic [AW-1:0]       rd_addr,
  input  logic [LAT_W-1:0]    rd_lat,
  input  logic                wb_we,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic                stall,
  output logic                issue,
  output logic [NREGS-1:0]    pending
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [LAT_W-1:0] r_cnt  [NREGS];

  logic [AW-1:0] w_ra [NRD];
  logic          w_wb_en;
  logic          w_raw;
  logic          w_waw;
  logic          w_set;

  always_comb begin
    for (int unsigned i = 0; i < NRD; i++) begin
      w_ra[i] = rs_addr[i*AW +: AW];
    end
  end

  assign w_wb_en = wb_we && (wb_addr != '0);

  // Read ports bypass the same-cycle write-back so WB->ID needs no extra bubble.
  always_comb begin
    rs_data = '0;
    w_raw   = 1'b0;
    for (int unsigned i = 0; i < NRD; i++) begin
      if (w_ra[i] == '0) begin
        rs_data[i*XLEN +: XLEN] = '0;
      end else if (w_wb_en && (wb_addr == w_ra[i])) begin
        rs_data[i*XLEN +: XLEN] = wb_data;
      end else begin
        rs_data[i*XLEN +: XLEN] = r_regs[w_ra[i]];
      end
      if (rs_used[i] && (w_ra[i] != '0) && (r_cnt[w_ra[i]] != '0)) begin
        w_raw = 1'b1;
      end
    end
  end

  // A younger writer may only issue once the older result retires no later than its own.
  assign w_waw = rd_we && (rd_addr != '0) && (r_cnt[rd_addr] > rd_lat);
  assign stall = id_valid && !flush && (w_raw || w_waw);
  assign issue = id_valid && !flush && !stall;
  assign w_set = issue && rd_we;

  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      pending[r] = (r_cnt[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        r_cnt[r] <= '0;
      end
    end else begin
      r_cnt[0] <= '0;
      for (int unsigned r = 1; r < NREGS; r++) begin
        if (w_set && (rd_addr == AW'(r))) begin
          r_cnt[r] <= rd_lat;
        end else if (r_cnt[r] != '0) begin
          r_cnt[r] <= r_cnt[r] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        r_regs[r] <= '0;
      end
    end else if (w_wb_en) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

endmodule

// File: tb/tb_id_regfile_scoreboard.sv
// Bench for id_regfile_scoreboard: timestamp-based scoreboard model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_id_regfile_scoreboard;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int LAT_W = 3;
  localparam int AW    = $clog2(NREGS);

  logic                clk;
  logic                reset;
  logic                id_valid;
  logic                flush;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD-1:0]      rs_used;
  logic                rd_we;
  logic [AW-1:0]       rd_addr;
  logic [LAT_W-1:0]    rd_lat;
  logic                wb_we;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic [NRD*XLEN-1:0] rs_data;
  logic                stall;
  logic                issue;
  logic [NREGS-1:0]    pending;

  id_regfile_scoreboard #(
    .XLEN (XLEN),
    .NREGS(NREGS),
    .NRD  (NRD),
    .LAT_W(LAT_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .id_valid(id_valid),
    .flush   (flush),
    .rs_addr (rs_addr),
    .rs_used (rs_used),
    .rd_we   (rd_we),
    .rd_addr (rd_addr),
    .rd_lat  (rd_lat),
    .wb_we   (wb_we),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .rs_data (rs_data),
    .stall   (stall),
    .issue   (issue),
    .pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each register remembers the cycle at which its result becomes forwardable.
  int           ready_at [NREGS];
  logic [XLEN-1:0] mregs [NREGS];
  int           cyc;
  bit           model_on;
  int           n_pass;
  int           n_total;

  logic [XLEN-1:0]  s_rs [NRD];
  logic             s_stall;
  logic             s_issue;
  logic [NREGS-1:0] s_pend;

  function automatic int remaining(input int r);
    if (r == 0 || ready_at[r] <= cyc) return 0;
    return ready_at[r] - cyc;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic idle();
    reset    = 1'b0;
    id_valid = 1'b0;
    flush    = 1'b0;
    rs_addr  = '0;
    rs_used  = '0;
    rd_we    = 1'b0;
    rd_addr  = '0;
    rd_lat   = '0;
    wb_we    = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
  endtask

  task automatic set_rd(input int p, input int a, input bit used);
    rs_addr[p*AW +: AW] = AW'(a);
    rs_used[p]          = used;
  endtask

  task automatic set_dst(input int a, input int lat);
    rd_we   = 1'b1;
    rd_addr = AW'(a);
    rd_lat  = LAT_W'(lat);
  endtask

  task automatic step();
    bit               e_raw;
    bit               e_waw;
    bit               e_stall;
    bit               e_issue;
    logic [NREGS-1:0] e_pend;
    logic [XLEN-1:0]  e_rs;
    int               a;
    @(negedge clk);
    e_raw = 0;
    for (int p = 0; p < NRD; p++) begin
      a = int'(rs_addr[p*AW +: AW]);
      if (rs_used[p] && a != 0 && remaining(a) > 0) e_raw = 1;
    end
    e_waw   = rd_we && rd_addr != 0 && remaining(int'(rd_addr)) > int'(rd_lat);
    e_stall = id_valid && !flush && (e_raw || e_waw);
    e_issue = id_valid && !flush && !e_stall;
    for (int r = 0; r < NREGS; r++) e_pend[r] = (remaining(r) > 0);
    for (int p = 0; p < NRD; p++) s_rs[p] = rs_data[p*XLEN +: XLEN];
    s_stall = stall;
    s_issue = issue;
    s_pend  = pending;
    if (model_on) begin
      for (int p = 0; p < NRD; p++) begin
        a = int'(rs_addr[p*AW +: AW]);
        if (a == 0) e_rs = '0;
        else if (wb_we && int'(wb_addr) == a) e_rs = wb_data;
        else e_rs = mregs[a];
        chk($sformatf("model_rs_data%0d", p), 64'(s_rs[p]), 64'(e_rs));
      end
      chk("model_stall", 64'(s_stall), 64'(e_stall));
      chk("model_issue", 64'(s_issue), 64'(e_issue));
      chk("model_pending", 64'(s_pend), 64'(e_pend));
    end
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        ready_at[r] = 0;
        mregs[r]    = '0;
      end
    end else begin
      if (wb_we && wb_addr != 0) mregs[wb_addr] = wb_data;
      if (e_issue && rd_we && rd_addr != 0) ready_at[rd_addr] = cyc + 1 + int'(rd_lat);
    end
    cyc++;
    #1;
  endtask

  initial begin
    int n_st;
    int n_pd;
    bit went;
    n_pass   = 0;
    n_total  = 0;
    cyc      = 0;
    model_on = 0;
    for (int r = 0; r < NREGS; r++) begin
      ready_at[r] = 0;
      mregs[r]    = '0;
    end
    idle();
    reset = 1'b1;
    #1;
    step();
    model_on = 1;
    step();
    idle();

    // Reset state across every address
    for (int a = 0; a < NREGS; a++) begin
      id_valid = 1'b1;
      set_rd(0, a, 1'b1);
      set_rd(1, NREGS - 1 - a, 1'b1);
      step();
      chk("reset_rs0_zero", 64'(s_rs[0]), 64'h0);
      chk("reset_rs1_zero", 64'(s_rs[1]), 64'h0);
      chk("reset_stall_zero", 64'(s_stall), 64'h0);
      chk("reset_pending_zero", 64'(s_pend), 64'h0);
    end
    idle();
    wb_we = 1'b1; wb_addr = '0; wb_data = 32'h1234;
    step();
    chk("x0_write_bypass", 64'(s_rs[0]), 64'h0);
    idle();
    step();
    chk("x0_write_ignored", 64'(s_rs[0]), 64'h0);

    // Write-back bypass and persistence
    idle();
    wb_we = 1'b1; wb_addr = AW'(5); wb_data = 32'hDEADBEEF;
    set_rd(0, 5, 1'b0);
    step();
    chk("wb_bypass_same_cycle", 64'(s_rs[0]), 64'hDEADBEEF);
    idle();
    set_rd(0, 5, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("wb_array_later", 64'(s_rs[0]), 64'hDEADBEEF);
    end

    // Load-use, latency 1
    idle(); id_valid = 1'b1; set_dst(7, 1);
    step();
    chk("lat1_producer_issue", 64'(s_issue), 64'h1);
    idle(); id_valid = 1'b1; set_rd(0, 7, 1'b1);
    step();
    chk("lat1_dep_stall", 64'(s_stall), 64'h1);
    step();
    chk("lat1_dep_issue", 64'(s_issue), 64'h1);
    chk("lat1_dep_nostall", 64'(s_stall), 64'h0);
    idle(); id_valid = 1'b1; set_dst(7, 1);
    step();
    idle(); id_valid = 1'b1; set_rd(0, 7, 1'b0);
    step();
    chk("unused_port_nostall", 64'(s_stall), 64'h0);
    chk("unused_port_issue", 64'(s_issue), 64'h1);

    // Latency 4 RAW
    idle(); id_valid = 1'b1; set_dst(3, 4);
    step();
    idle(); id_valid = 1'b1; set_rd(0, 3, 1'b1);
    n_st = 0; n_pd = 0; went = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (s_pend[3]) n_pd++;
      if (s_issue) begin went = 1; break; end
      if (s_stall) n_st++;
    end
    chk("lat4_issued", 64'(went), 64'h1);
    chk("lat4_stall_cycles", 64'(n_st), 64'd4);
    chk("lat4_pending_cycles", 64'(n_pd), 64'd4);
    idle(); id_valid = 1'b1; set_dst(3, 4);
    step();
    idle(); id_valid = 1'b1; set_rd(0, 4, 1'b1);
    step();
    chk("independent_issue", 64'(s_issue), 64'h1);
    idle();
    for (int k = 0; k < 5; k++) step();

    // WAW: older lat 5, younger lat 1
    idle(); id_valid = 1'b1; set_dst(3, 5);
    step();
    set_dst(3, 1);
    n_st = 0; went = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (s_issue) begin went = 1; break; end
      if (s_stall) n_st++;
    end
    chk("waw_issued", 64'(went), 64'h1);
    chk("waw_stall_cycles", 64'(n_st), 64'd4);
    idle();
    step();
    chk("waw_reload_pending", 64'(s_pend[3]), 64'h1);
    step();
    chk("waw_reload_done", 64'(s_pend[3]), 64'h0);

    // Flush with hazard, then reset mid-latency
    idle(); id_valid = 1'b1; set_dst(3, 4);
    step();
    idle(); id_valid = 1'b1; flush = 1'b1; set_rd(0, 3, 1'b1);
    step();
    chk("flush_stall", 64'(s_stall), 64'h0);
    chk("flush_issue", 64'(s_issue), 64'h0);
    idle(); reset = 1'b1;
    step();
    chk("pre_reset_pending3", 64'(s_pend[3]), 64'h1);
    idle(); set_rd(0, 5, 1'b0);
    step();
    chk("post_reset_pending", 64'(s_pend), 64'h0);
    chk("post_reset_regs", 64'(s_rs[0]), 64'h0);

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      reset    = ($urandom_range(0, 63) == 0);
      id_valid = ($urandom_range(0, 9) < 8);
      flush    = ($urandom_range(0, 9) == 0);
      for (int p = 0; p < NRD; p++) begin
        if ($urandom_range(0, 3) == 0) set_rd(p, int'($urandom_range(0, NREGS - 1)), 1'($urandom_range(0, 1)));
        else set_rd(p, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end
      rd_we   = 1'($urandom_range(0, 1));
      rd_addr = AW'($urandom_range(0, 7));
      rd_lat  = LAT_W'($urandom_range(0, (1 << LAT_W) - 1));
      wb_we   = 1'($urandom_range(0, 1));
      wb_addr = AW'($urandom_range(0, 7));
      wb_data = $urandom();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
